aes_enc_core: RTL and testbench
===============================

// Module: aes_enc_core
// PURPOSE
// - Iterative AES encryption engine, one round per clock, with key length fixed at compile time (128/192/256).
// - Successor to the fixed AES-128 top_encryption block. Adds a stored expanded key, valid/ready streaming
//   on input and output, and optional CBC chaining.
// - Sits between the host-side block buffer and the ciphertext sink in the accelerator datapath.
// PARAMETERS
// - KEY_BITS  256  cipher key length; legal values 128, 192, 256. Sets NK = KEY_BITS/32 and NR = NK+6.
// PORTS
// - clk          in   1         clock; all logic on the rising edge
// - reset_n      in   1         asynchronous, active-low reset
// - restart      in   1         synchronous abort of the in-flight block; the key is retained
// - key_load     in   1         one-cycle pulse; samples key_in and starts key expansion
// - key_in       in   KEY_BITS  cipher key; bit KEY_BITS-1 is the first key byte MSB
// - key_ready    out  1         expanded key valid
// - in_valid     in   1         plaintext block offered
// - in_ready     out  1         core accepts a block
// - in_data      in   128       plaintext block; bits [127:120] are byte 0
// - out_valid    out  1         ciphertext valid; held until the handshake completes
// - out_ready    in   1         sink accepts the ciphertext
// - out_data     out  128       ciphertext block
// - iv_load      in   1         [CBC_EN only] load the chaining register from iv_in
// - iv_in        in   128       [CBC_EN only] initialisation vector
// BEHAVIOUR
// - Reset state: key_ready=0, in_ready=0, out_valid=0, out_data=0; round-key store cleared; FSM in IDLE.
// - Key expansion: on key_load, the engine writes key words w[0..NK-1] from key_in, then generates one word per
//   cycle per FIPS-197 (RotWord/SubWord/Rcon at i%NK==0; SubWord only at i%NK==4 when NK==8).
//   - E = 4*(NR+1)-NK generated words: 40 / 46 / 52.
//   - key_ready drops the cycle after key_load and rises E+1 cycles after key_load.
//   - key_load during expansion restarts the expansion.
//   - key_load while a block is in ROUND or DONE is ignored.
// - in_ready = (state==IDLE) && key_ready && !key_load && !restart. A block is accepted when in_valid && in_ready.
// - FSM: IDLE -> ROUND on accept; ROUND -> DONE after round NR; DONE -> IDLE on out_valid && out_ready.
//   - Accept at cycle T: state <= in_data ^ rk[0] at T+1.
//   - Rounds 1..NR-1 are full rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey), one per cycle.
//   - Round NR omits MixColumns.
//   - out_valid rises at T+NR+1, i.e. latency 11 / 13 / 15 cycles.
// - out_data/out_valid are stable while out_valid && !out_ready. in_ready reasserts the cycle after the output handshake.
// - restart (any state): next cycle FSM=IDLE, out_valid=0. The in-flight block is discarded. Round keys and key_ready are unchanged.
//   restart during expansion aborts it and leaves key_ready=0.
// - Priority: reset_n > restart > key_load > in_valid.
// - Round counter width: $clog2(NR+1). Word counter wraps nowhere; it saturates at 4*(NR+1).
// CONFIGURATION
// - CBC_EN defined: iv_load/iv_in ports exist; 128-bit chain register (reset 0).
//   - iv_load is honoured only in IDLE and takes priority over in_valid in the same cycle (in_ready=0).
//   - On accept, the core encrypts in_data ^ chain. On the output handshake, chain <= out_data.
//   - key_load and restart leave chain unchanged.
// - CBC_EN undefined: ports absent; ECB mode; the block is encrypted directly.
// STRUCTURE
// - aes_pkg: sbox[256] constant table, rcon[10], state_t (enum IDLE/ROUND/DONE), functions sub_word,
//   shift_rows, mix_columns, xtime, and nr_of(key_bits).
// - Sub-module aes_key_expand: owns key_load/key_ready, the word generator and the round-key store,
//   and exposes a read port rk[round].
// - The datapath round logic stays in aes_enc_core.
// TESTING
// - KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff
//   -> 69c4e0d86a7b0430d8cdb78070b4c55a; key_ready 41 cycles after key_load; out_valid 11 cycles after accept.
// - KEY_BITS=192 key 000102..17 -> dda97ca4864cdfe06eaf70a0ec0d7191.
//   KEY_BITS=256 key 000102..1f -> 8ea2b7ca516745bfeafc49904b496089 (same pt).
// - Backpressure: key 2b7e151628aed2a6abf7158809cf4f3c, pt 6bc1bee22e409f96e93d7e117393172a,
//   out_ready low 20 cycles -> out_data 3ad77bb40d7a3660a89ecaf32466ef97 held stable; second block accepted only after the handshake.
// - restart asserted 5 cycles after accept -> out_valid never rises; the next block with the same key is still correct.
//   reset_n low mid-expansion -> key_ready=0, in_ready=0.
// - key_load in the same cycle as in_valid in IDLE -> no accept; key_load during ROUND -> ignored, result unchanged.
// - CBC_EN, KEY_BITS=128: iv 000102..0f, key 2b7e1516.., pt 6bc1bee22e409f96e93d7e117393172a
//   -> 7649abac8119b246cee98e9b12e9197d; next pt ae2d8a571e03ac9c9eb76fac45af8e51 -> 5086cb9b507219ee95db113a917678b2.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative encryption core.
//   SBOX / RCON    : FIPS-197 substitution table and round constants
//   state_t        : datapath FSM states
//   sub_byte/sub_word/rot_word, sub_bytes, shift_rows, mix_columns, xtime : round primitives
//   nr_of          : number of rounds for a given key length
// State layout everywhere: bits [127:120] are byte 0, bytes fill columns first (byte = 4*col + row).
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

  function automatic int unsigned nr_of(input int unsigned key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) begin
      r[127-8*k -: 8] = sub_byte(s[127-8*k -: 8]);
    end
    return r;
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+rw)%4)+rw) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_key_expand.sv
// AES key schedule: stores the expanded key and serves one round key per read.
//   i_clk, i_reset_n  : clock, asynchronous active-low reset (clears the word store)
//   i_restart         : aborts an in-progress expansion (key_ready stays low)
//   i_key_load        : one-cycle pulse, samples i_key and starts expansion
//   i_key             : cipher key, MSB is the first key byte
//   i_core_busy       : datapath is mid-block; key_load is ignored while set
//   i_rd_round        : round-key index
//   o_rd_key          : round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   o_key_ready       : every word of the schedule is valid
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 256
) (
  input  logic                                      i_clk,
  input  logic                                      i_reset_n,
  input  logic                                      i_restart,
  input  logic                                      i_key_load,
  input  logic [KEY_BITS-1:0]                       i_key,
  input  logic                                      i_core_busy,
  input  logic [$clog2(nr_of(KEY_BITS)+1)-1:0]      i_rd_round,
  output logic [127:0]                              o_rd_key,
  output logic                                      o_key_ready
);

  localparam int unsigned NK    = KEY_BITS / 32;
  localparam int unsigned NR    = nr_of(KEY_BITS);
  localparam int unsigned TOTAL = 4 * (NR + 1);
  localparam int unsigned CW    = $clog2(TOTAL + 1);

  logic [0:TOTAL-1][31:0] r_w;
  logic [CW-1:0]          r_cnt;        // next word index; parks at TOTAL when idle
  logic [2:0]             r_phase;      // r_cnt mod NK, tracked incrementally
  logic [3:0]             r_rcon_idx;
  logic                   r_expanding;
  logic                   r_key_ready;

  logic                   w_load;
  logic [CW-1:0]          w_base;
  logic [31:0]            w_prev;
  logic [31:0]            w_back;
  logic [31:0]            w_temp;
  logic [31:0]            w_new;

  assign w_load      = i_key_load && !i_restart && !i_core_busy;
  assign w_base      = CW'({i_rd_round, 2'b00});
  assign o_rd_key    = r_w[w_base +: 4];
  assign o_key_ready = r_key_ready;

  always_comb begin
    w_prev = r_w[r_cnt - CW'(1)];
    w_back = r_w[r_cnt - CW'(NK)];
    w_temp = w_prev;
    if (r_phase == 3'd0) begin
      w_temp = sub_word(rot_word(w_prev)) ^ {RCON[r_rcon_idx], 24'h000000};
    end else if (NK == 8 && r_phase == 3'd4) begin
      w_temp = sub_word(w_prev);
    end
    w_new = w_back ^ w_temp;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_w         <= '0;
      r_cnt       <= CW'(TOTAL);
      r_phase     <= 3'd0;
      r_rcon_idx  <= 4'd0;
      r_expanding <= 1'b0;
      r_key_ready <= 1'b0;
    end else if (i_restart) begin
      // key_ready is already low while expanding, so an abort leaves it low.
      r_expanding <= 1'b0;
    end else if (w_load) begin
      r_w[0:NK-1] <= i_key;
      r_cnt       <= CW'(NK);
      r_phase     <= 3'd0;
      r_rcon_idx  <= 4'd0;
      r_expanding <= 1'b1;
      r_key_ready <= 1'b0;
    end else if (r_expanding) begin
      r_w[r_cnt] <= w_new;
      r_cnt      <= r_cnt + CW'(1);
      r_phase    <= (r_phase == 3'(NK - 1)) ? 3'd0 : r_phase + 3'd1;
      if (r_phase == 3'd0) begin
        r_rcon_idx <= r_rcon_idx + 4'd1;
      end
      if (r_cnt == CW'(TOTAL - 1)) begin
        r_expanding <= 1'b0;
        r_key_ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_enc_core.sv
// Iterative AES encryption engine, one round per clock, key length fixed by KEY_BITS.
//   clk, reset_n        : clock, asynchronous active-low reset
//   restart             : synchronous abort of the in-flight block; key is kept
//   key_load, key_in    : start key expansion; key_ready flags the schedule as usable
//   in_valid/in_ready/in_data    : plaintext handshake
//   out_valid/out_ready/out_data : ciphertext handshake, output held under backpressure
//   iv_load, iv_in      : chaining-register load (only when CBC_EN is defined)
// Build option: define CBC_EN for CBC chaining; otherwise blocks are encrypted independently (ECB).
module aes_enc_core
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                restart,
  input  logic                key_load,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                key_ready,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data
`ifdef CBC_EN
  ,
  input  logic                iv_load,
  input  logic [127:0]        iv_in
`endif
);

  localparam int unsigned NR = nr_of(KEY_BITS);
  localparam int unsigned RW = $clog2(NR + 1);

  state_t          r_state;
  logic [RW-1:0]   r_round;
  logic [127:0]    r_data;
  logic [127:0]    r_out_data;
  logic            r_out_valid;

  logic [RW-1:0]   w_rk_idx;
  logic [127:0]    w_rk;
  logic [127:0]    w_block;
  logic [127:0]    w_shifted;
  logic [127:0]    w_round_out;
  logic            w_last;
  logic            w_accept;
  logic            w_iv_take;

  // The single round-key port serves rk[0] at accept and rk[round] while iterating.
  assign w_rk_idx = (r_state == ROUND) ? r_round : '0;

  aes_key_expand #(
    .KEY_BITS (KEY_BITS)
  ) u_key_expand (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_restart   (restart),
    .i_key_load  (key_load),
    .i_key       (key_in),
    .i_core_busy (r_state != IDLE),
    .i_rd_round  (w_rk_idx),
    .o_rd_key    (w_rk),
    .o_key_ready (key_ready)
  );

`ifdef CBC_EN
  logic [127:0] r_chain;
  logic         w_handshake;

  assign w_iv_take   = iv_load && (r_state == IDLE);
  assign w_handshake = r_out_valid && out_ready && !restart;
  assign w_block     = in_data ^ r_chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= '0;
    end else if (w_iv_take) begin
      r_chain <= iv_in;
    end else if (w_handshake) begin
      r_chain <= r_out_data;
    end
  end
`else
  assign w_iv_take = 1'b0;
  assign w_block   = in_data;
`endif

  assign in_ready  = (r_state == IDLE) && key_ready && !key_load && !restart && !w_iv_take;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Final round skips MixColumns.
  assign w_last      = (r_round == RW'(NR));
  assign w_shifted   = shift_rows(sub_bytes(r_data));
  assign w_round_out = (w_last ? w_shifted : mix_columns(w_shifted)) ^ w_rk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_round     <= '0;
      r_data      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (restart) begin
      r_state     <= IDLE;
      r_round     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data  <= w_block ^ w_rk;
            r_round <= RW'(1);
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_data <= w_round_out;
          if (w_last) begin
            r_out_data  <= w_round_out;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_round <= r_round + RW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_core.sv
module tb_aes_enc_core;

  localparam logic [127:0] K0    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT0   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT1   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT2   = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] IV    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CBC1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CBC2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K256  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, restart, key_load, in_valid, out_ready;
  logic [127:0] key_in, in_data;
  logic         key_ready, in_ready, out_valid;
  logic [127:0] out_data;

  logic         key_load_b, in_valid_b;
  logic         kr192, ir192, ov192, kr256, ir256, ov256;
  logic [127:0] od192, od256;

`ifdef CBC_EN
  logic         iv_load;
  logic [127:0] iv_in;
`endif

  int   n_pass   = 0;
  int   n_checks = 0;
  int   n, n192, n256;
  logic seen;

  aes_enc_core #(.KEY_BITS(128)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart   (restart),
    .key_load  (key_load),
    .key_in    (key_in),
    .key_ready (key_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef CBC_EN
    ,
    .iv_load   (iv_load),
    .iv_in     (iv_in)
`endif
  );

  aes_enc_core #(.KEY_BITS(192)) u_dut192 (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart   (1'b0),
    .key_load  (key_load_b),
    .key_in    (K192),
    .key_ready (kr192),
    .in_valid  (in_valid_b),
    .in_ready  (ir192),
    .in_data   (PT0),
    .out_valid (ov192),
    .out_ready (1'b1),
    .out_data  (od192)
`ifdef CBC_EN
    ,
    .iv_load   (1'b0),
    .iv_in     (128'h0)
`endif
  );

  aes_enc_core #(.KEY_BITS(256)) u_dut256 (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart   (1'b0),
    .key_load  (key_load_b),
    .key_in    (K256),
    .key_ready (kr256),
    .in_valid  (in_valid_b),
    .in_ready  (ir256),
    .in_data   (PT0),
    .out_valid (ov256),
    .out_ready (1'b1),
    .out_data  (od256)
`ifdef CBC_EN
    ,
    .iv_load   (1'b0),
    .iv_in     (128'h0)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_blk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Pulse key_load and count cycles until key_ready (cycle 1 = cycle after key_load).
  task automatic load_key(input logic [127:0] k, input string tag);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    n = 1;
    check_bit({tag, "_drop"}, key_ready, 1'b0);
    while (!key_ready && n < 100) begin
      tick();
      n++;
    end
    check_int({tag, "_lat"}, n, 41);
  endtask

  // Called right after the accept edge; counts cycles until out_valid (bounded).
  task automatic wait_out();
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    restart    = 1'b0;
    key_load   = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    key_in     = '0;
    in_data    = '0;
    key_load_b = 1'b0;
    in_valid_b = 1'b0;
`ifdef CBC_EN
    iv_load    = 1'b0;
    iv_in      = '0;
`endif
    repeat (3) tick();
    check_bit("rst_key_ready", key_ready, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_blk("rst_out_data", out_data, 128'h0);
    reset_n = 1'b1;
    tick();

    // Reset in the middle of expansion must kill it for good.
    key_in   = K0;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    check_bit("midexp_rst_key_ready", key_ready, 1'b0);
    check_bit("midexp_rst_in_ready", in_ready, 1'b0);
    #2;
    reset_n = 1'b1;
    repeat (50) tick();
    check_bit("midexp_rst_stays_low", key_ready, 1'b0);

`ifdef CBC_EN
    load_key(K1, "cbc_key");
    iv_in   = IV;
    iv_load = 1'b1;
    in_data = PT1;
    in_valid = 1'b1;
    #1;
    check_bit("cbc_iv_prio_in_ready", in_ready, 1'b0);
    tick();
    iv_load = 1'b0;
    #1;
    check_bit("cbc_in_ready_after_iv", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    wait_out();
    check_int("cbc_lat1", n, 11);
    check_blk("cbc_ct1", out_data, CBC1);
    tick();
    in_data  = PT2;
    in_valid = 1'b1;
    #1;
    check_bit("cbc_in_ready2", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    wait_out();
    check_int("cbc_lat2", n, 11);
    check_blk("cbc_ct2", out_data, CBC2);
    tick();
`else
    load_key(K0, "key0");

    // key_load and in_valid together in IDLE: key reloads, block is not taken.
    in_data  = PT0;
    in_valid = 1'b1;
    key_load = 1'b1;
    #1;
    check_bit("kl_vs_iv_in_ready", in_ready, 1'b0);
    tick();
    key_load = 1'b0;
    in_valid = 1'b0;
    n = 1;
    seen = 1'b0;
    check_bit("kl_vs_iv_drop", key_ready, 1'b0);
    while (!key_ready && n < 100) begin
      if (out_valid) seen = 1'b1;
      tick();
      n++;
    end
    check_int("kl_vs_iv_relat", n, 41);
    check_bit("kl_vs_iv_no_out", seen, 1'b0);

    // FIPS-197 vector; a key_load mid-block must be ignored.
    in_data  = PT0;
    in_valid = 1'b1;
    #1;
    check_bit("fips_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    key_in   = K1;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    check_bit("kl_round_keep_ready", key_ready, 1'b1);
    n = 4;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check_int("fips_lat", n, 11);
    check_blk("fips_ct", out_data, CT0);
    tick();
    check_bit("fips_hs_out_valid", out_valid, 1'b0);
    check_bit("fips_hs_in_ready", in_ready, 1'b1);

    // Backpressure with a second block waiting.
    load_key(K1, "key1");
    out_ready = 1'b0;
    in_data   = PT1;
    in_valid  = 1'b1;
    tick();
    in_data = PT2;
    wait_out();
    check_int("bp_lat", n, 11);
    for (int i = 0; i < 20; i++) begin
      check_bit("bp_out_valid", out_valid, 1'b1);
      check_blk("bp_out_data", out_data, CT1);
      check_bit("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check_bit("bp_after_hs_valid", out_valid, 1'b0);
    check_bit("bp_after_hs_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    wait_out();
    check_int("bp_blk2_lat", n, 11);
    check_blk("bp_blk2_ct", out_data, CT2);
    tick();

    // Restart five cycles after accept discards the block, keeps the key.
    in_data  = PT1;
    in_valid = 1'b1;
    #1;
    check_bit("rs_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check_bit("rs_no_out_valid", seen, 1'b0);
    check_bit("rs_key_kept", key_ready, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out();
    check_int("rs_again_lat", n, 11);
    check_blk("rs_again_ct", out_data, CT1);
    tick();
`endif

    // 192- and 256-bit keys, loaded and run side by side.
    key_load_b = 1'b1;
    tick();
    key_load_b = 1'b0;
    n192 = 0;
    n256 = 0;
    for (int c = 1; c < 100; c++) begin
      if (kr192 && n192 == 0) n192 = c;
      if (kr256 && n256 == 0) n256 = c;
      if (n192 != 0 && n256 != 0) break;
      tick();
    end
    check_int("k192_lat", n192, 47);
    check_int("k256_lat", n256, 53);
    in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    n192 = 0;
    n256 = 0;
    for (int c = 1; c < 40; c++) begin
      if (ov192 && n192 == 0) begin
        n192 = c;
        check_blk("aes192_ct", od192, CT192);
      end
      if (ov256 && n256 == 0) begin
        n256 = c;
        check_blk("aes256_ct", od256, CT256);
      end
      if (n192 != 0 && n256 != 0) break;
      tick();
    end
    check_int("aes192_lat", n192, 13);
    check_int("aes256_lat", n256, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
